// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - segment patterns, FSM state type and pattern-to-hex lookup
//
// Patterns are segment-active (p = ~seg_n), bit6 = a ... bit0 = g.
// seg_to_hex returns {legal, value[3:0]}; value is 0 when not legal.

package sev_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110010;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Pattern the encoder emits for an out-of-range value, and the all-off pattern.
  localparam logic [6:0] SEG_ERR   = 7'b0001101;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {IDLE, TRACK, CAPTURE, HELD} state_t;

  function automatic logic [4:0] seg_to_hex(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
      SEG_A: r = {1'b1, 4'hA};
      SEG_B: r = {1'b1, 4'hB};
      SEG_C: r = {1'b1, 4'hC};
      SEG_D: r = {1'b1, 4'hD};
      SEG_E: r = {1'b1, 4'hE};
      SEG_F: r = {1'b1, 4'hF};
      // Error and all-off patterns are never a legal hex value.
      SEG_ERR, SEG_BLANK: r = 5'b0_0000;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sev_seg_decode.sv
// rtl/sev_seg_decode.sv - combinational segment pattern to {legal, blank, value} decode
//
// Ports:
//   p      in  7  segment-active pattern (bit6 = a ... bit0 = g)
//   legal  out 1  pattern is one of the sixteen hex glyphs
//   blank  out 1  pattern is all-off (only with SEV_SEG_CAPTURE_BLANK_EN, else 0)
//   value  out 4  decoded hex value, 0 when not legal
// Macro: SEV_SEG_CAPTURE_BLANK_EN enables blank detection.

module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [6:0] p,
  output logic       legal,
  output logic       blank,
  output logic [3:0] value
);

  logic [4:0] hex;

  assign hex   = seg_to_hex(p);
  assign legal = hex[4];
  assign value = hex[3:0];

`ifdef SEV_SEG_CAPTURE_BLANK_EN
  assign blank = (p == SEG_BLANK);
`else
  assign blank = 1'b0;
`endif

endmodule

// File: rtl/sev_seg_capture.sv
// rtl/sev_seg_capture.sv - seven-segment receive side: rebuilds hex digits from a multiplexed bus
//
// Ports:
//   clk           in  1             system clock
//   rst_n         in  1             asynchronous active-low reset
//   seg_n         in  7             segment bus, active-low, bit6 = a ... bit0 = g
//   dig_n         in  NUM_DIGITS    digit strobes, active-low, expected one-hot
//   clear         in  1             synchronous clear of all captured state
//   digits        out 4*NUM_DIGITS  decoded values, digit i at [4i+3:4i]
//   digit_valid   out NUM_DIGITS    digit i holds a legal decode
//   digit_err     out NUM_DIGITS    last stable pattern on digit i was illegal
//   digit_blank   out NUM_DIGITS    last stable pattern on digit i was all-off
//   frame_done    out 1             pulse when every digit was captured since the last pulse
//   strobe_fault  out 1             sticky: several strobes seen active together
// Macro: SEV_SEG_CAPTURE_BLANK_EN reports all-off digits on digit_blank instead of digit_err.

module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_n,
  input  logic                      clear,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     digit_err,
  output logic [NUM_DIGITS-1:0]     digit_blank,
  output logic                      frame_done,
  output logic                      strobe_fault
);

  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Synchronizer holds active-high copies so the all-zero reset value means
  // "no strobe, no segment" rather than "every strobe active".
  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] dig_s1, dig_s2;

  logic [3:0]            act_cnt;
  logic [KW-1:0]         act_idx;
  logic                  sel_one;
  logic                  sel_multi;
  logic                  changed;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [6:0]            pat_q;
  logic [KW-1:0]         k_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0] valid_q, err_q, blank_q, seen_q;
  logic                  frame_q, fault_q;

  logic [NUM_DIGITS-1:0] seen_set;
  logic                  dec_legal, dec_blank;
  logic [3:0]            dec_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else if (clear) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= ~seg_n;
      seg_s2 <= seg_s1;
      dig_s1 <= ~dig_n;
      dig_s2 <= dig_s1;
    end
  end

  // Count active strobes; act_idx is only meaningful when exactly one is active.
  always_comb begin
    act_cnt = '0;
    act_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s2[i]) begin
        act_cnt = act_cnt + 4'd1;
        act_idx = KW'(i);
      end
    end
  end

  assign sel_one   = (act_cnt == 4'd1);
  assign sel_multi = (act_cnt > 4'd1);
  assign changed   = (seg_s2 != pat_q) || (act_idx != k_q);
  assign seen_set  = seen_q | (NUM_DIGITS'(1) << k_q);

  sev_seg_decode u_decode (
    .p     (pat_q),
    .legal (dec_legal),
    .blank (dec_blank),
    .value (dec_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      k_q      <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      blank_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      k_q      <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      blank_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (sel_multi) fault_q <= 1'b1;

      case (state)
        IDLE: begin
          if (sel_one) begin
            state <= TRACK;
            cnt   <= CNT_W'(1);
            pat_q <= seg_s2;
            k_q   <= act_idx;
          end
        end

        TRACK: begin
          if (!sel_one) begin
            state <= IDLE;
          end else if (changed) begin
            cnt   <= CNT_W'(1);
            pat_q <= seg_s2;
            k_q   <= act_idx;
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            // This sample is the STABLE_CYCLES-th identical one.
            cnt   <= cnt + CNT_W'(1);
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CAPTURE: begin
          if (dec_legal) begin
            digits_q[{k_q, 2'b00} +: 4] <= dec_value;
            valid_q[k_q] <= 1'b1;
            err_q[k_q]   <= 1'b0;
            blank_q[k_q] <= 1'b0;
          end else if (dec_blank) begin
            valid_q[k_q] <= 1'b0;
            err_q[k_q]   <= 1'b0;
            blank_q[k_q] <= 1'b1;
          end else begin
            // Illegal pattern: keep the last good value, flag the digit.
            valid_q[k_q] <= 1'b0;
            err_q[k_q]   <= 1'b1;
            blank_q[k_q] <= 1'b0;
          end
          if (&seen_set) begin
            seen_q  <= '0;
            frame_q <= 1'b1;
          end else begin
            seen_q <= seen_set;
          end
          state <= HELD;
        end

        HELD: begin
          if (!sel_one) begin
            state <= IDLE;
          end else if (changed) begin
            state <= TRACK;
            cnt   <= CNT_W'(1);
            pat_q <= seg_s2;
            k_q   <= act_idx;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign digits       = digits_q;
  assign digit_valid  = valid_q;
  assign digit_err    = err_q;
  assign digit_blank  = blank_q;
  assign frame_done   = frame_q;
  assign strobe_fault = fault_q;

endmodule

// File: tb/tb_sev_seg_capture.sv
// tb/tb_sev_seg_capture.sv - scoreboard bench for sev_seg_capture with directed vectors

module tb_sev_seg_capture;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
    logic [3:0]  b;
    logic        f;
    logic        s;
  } snap_t;

  localparam logic [6:0] P1   = 7'b0110000;
  localparam logic [6:0] P2   = 7'b1101101;
  localparam logic [6:0] P3   = 7'b1111001;
  localparam logic [6:0] P5   = 7'b1011011;
  localparam logic [6:0] P7   = 7'b1110010;
  localparam logic [6:0] P8   = 7'b1111111;
  localparam logic [6:0] PA   = 7'b1110111;
  localparam logic [6:0] PF   = 7'b1000111;
  localparam logic [6:0] PERR = 7'b0001101;
  localparam logic [6:0] POFF = 7'b0000000;
  localparam snap_t      ZERO = '0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        clear;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_err, digit_blank;
  logic        frame_done, strobe_fault;

  snap_t cur;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_fail = 0;
  int    t0;
  logic  mon_en = 1'b0;

  snap_t exp_q[$];
  int    cyc_q[$];
  string name_q[$];

  sev_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .dig_n        (dig_n),
    .clear        (clear),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .digit_err    (digit_err),
    .digit_blank  (digit_blank),
    .frame_done   (frame_done),
    .strobe_fault (strobe_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cur = {digits, digit_valid, digit_err, digit_blank, frame_done, strobe_fault};

  // c < 0: output change expected, its cycle is not checked.
  task automatic expect_ev(string nm, int c, logic [15:0] d, logic [3:0] v,
                           logic [3:0] e, logic [3:0] b, logic f, logic s);
    snap_t x;
    x = {d, v, e, b, f, s};
    exp_q.push_back(x);
    cyc_q.push_back(c);
    name_q.push_back(nm);
  endtask

  task automatic check(string nm, snap_t got, snap_t want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic drive(logic [3:0] dn, logic [6:0] p);
    dig_n = dn;
    seg_n = ~p;
  endtask

  task automatic hold(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the observable outputs is one DUT response.
  initial begin
    snap_t prev, e;
    int    ec;
    string nm;
    wait (mon_en);
    @(negedge clk);
    prev = cur;
    forever begin
      @(negedge clk);
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h at cycle %0d, expected no change", cur, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== e || (ec >= 0 && cyc != ec)) begin
            n_fail++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", nm, cur, cyc, e, ec);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Expected write cycle: first sampling edge (t0) + 2 sync + 8 stable samples.
  initial begin
    rst_n = 1'b1;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    clear = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", cur, ZERO);
    hold(3);
    rst_n = 1'b1;
    hold(3);
    mon_en = 1'b1;
    hold(2);

    // Single digit, held beyond the stability window.
    t0 = cyc + 1;
    expect_ev("d2_three", t0 + 10, 16'h0300, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1011, P3);
    hold(12);
    drive(4'hF, POFF);
    hold(4);

    // Scan all four digits; digit 2 is already seen, so only the 4th capture pulses.
    t0 = cyc + 1;
    expect_ev("scan_d0", t0 + 10, 16'h0301, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1110, P1);
    hold(10);
    t0 = cyc + 1;
    expect_ev("scan_d1", t0 + 10, 16'h0321, 4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1101, P2);
    hold(10);
    t0 = cyc + 1;
    expect_ev("scan_d2", t0 + 10, 16'h0A21, 4'b0111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1011, PA);
    hold(10);
    t0 = cyc + 1;
    expect_ev("scan_d3_frame", t0 + 10, 16'hFA21, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    expect_ev("frame_pulse_end", t0 + 11, 16'hFA21, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b0111, PF);
    hold(10);
    drive(4'hF, POFF);
    hold(4);

    // Seven samples of '8' are one short; only the following '5' lands.
    drive(4'b1101, P8);
    hold(7);
    t0 = cyc + 1;
    expect_ev("restart_d1_five", t0 + 10, 16'hFA51, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1101, P5);
    hold(10);
    drive(4'hF, POFF);
    hold(4);

    // Error glyph on digit 0 keeps the old value.
    t0 = cyc + 1;
    expect_ev("err_d0", t0 + 10, 16'hFA51, 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b0);
    drive(4'b1110, PERR);
    hold(10);
    drive(4'hF, POFF);
    hold(4);

    // Two strobes at once: fault, no capture.
    t0 = cyc + 1;
    expect_ev("strobe_fault", t0 + 2, 16'hFA51, 4'b1110, 4'b0001, 4'b0000, 1'b0, 1'b1);
    drive(4'b1100, P1);
    hold(3);
    drive(4'hF, POFF);
    hold(14);
    expect_ev("clear_all", cyc + 1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    check("after_clear", cur, ZERO);
    hold(3);

    // All-off glyph on digit 3.
    t0 = cyc + 1;
`ifdef SEV_SEG_CAPTURE_BLANK_EN
    expect_ev("off_d3", t0 + 10, 16'h0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0);
`else
    expect_ev("off_d3", t0 + 10, 16'h0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0);
`endif
    drive(4'b0111, POFF);
    hold(10);
    drive(4'hF, POFF);
    hold(4);

    // Asynchronous reset in the middle of tracking.
    drive(4'b1110, P7);
    hold(5);
    #2;
    expect_ev("async_reset", -1, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 check("async_reset_now", cur, ZERO);
    @(posedge clk);
    #1;
    drive(4'hF, POFF);
    hold(2);
    rst_n = 1'b1;
    hold(14);

    // Capture works again from scratch after reset.
    t0 = cyc + 1;
    expect_ev("post_reset_d0", t0 + 10, 16'h0007, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b1110, P7);
    hold(10);
    drive(4'hF, POFF);
    hold(5);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
